chunked_serial_adder: RTL and testbench
=======================================

Name: chunked_serial_adder

Overview:
Multi-cycle parametrised successor to the combinational 1-bit full adder. Adds two WIDTH-bit operands plus a carry-in, CHUNK bits per clock, through a registered carry chain. Valid/ready handshakes on the input and output sides let it sit in a datapath where area matters more than latency. Outputs are sum, carry-out and signed overflow.

Parameters:
WIDTH, 16, operand and sum width in bits; must be >= 1.
CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH and WIDTH % CHUNK == 0 (elaboration-time check, fatal on violation).

Ports:
clk        input   1      single clock, rising edge
rst_n      input   1      asynchronous active-low reset
in_valid   input   1      operands a, b, cin valid
in_ready   output  1      block can accept operands
a          input   WIDTH  operand A
b          input   WIDTH  operand B
cin        input   1      carry-in
out_valid  output  1      result valid
out_ready  input   1      consumer accepts result
sum        output  WIDTH  a + b + cin, modulo 2^WIDTH
cout       output  1      unsigned carry-out
overflow   output  1      two's-complement overflow

Behaviour:
- The reset is asynchronous and active-low. While rst_n = 0: state = IDLE, in_ready = 0, out_valid = 0, sum = 0, cout = 0, overflow = 0, chunk counter = 0, operand regs = 0.
- in_ready is 1 only in IDLE, and only after rst_n has been released for at least one clock edge.
- NCHUNK = WIDTH / CHUNK.
- FSM IDLE:
  - On an edge with in_valid & in_ready, latch a, b, cin into the operand regs.
  - Load the carry register with cin, set cnt = 0 and go to RUN.
  - Otherwise stay in IDLE.
- FSM RUN:
  - Each cycle, combinationally add chunk cnt of a and b (bits cnt*CHUNK +: CHUNK) with the carry register.
  - At the edge, write the chunk result into sum[cnt*CHUNK +: CHUNK] and the chunk carry-out into the carry register.
  - When cnt = NCHUNK-1: also record cout = chunk carry-out and overflow = carry into MSB XOR carry out of MSB, then go to DONE. Otherwise cnt increments.
- FSM DONE:
  - out_valid = 1. sum, cout and overflow are stable and unchanged while out_valid & !out_ready.
  - On an edge with out_ready, go to IDLE, and out_valid falls at that edge.
- Latency: out_valid rises exactly NCHUNK edges after the input handshake edge. Throughput is at most one result per NCHUNK + 2 cycles.
- There is no back-to-back overlap: in_ready is 0 in RUN and DONE, and in_valid is ignored there.
- Input changes after the handshake have no effect (operands are registered).
- Unused sum bits during RUN hold their previous values; sum is only defined when out_valid = 1.
- Wrap-around: the result is modulo 2^WIDTH, and the carry out of the top chunk goes only to cout.
- Reset mid-operation (RUN or DONE): all outputs immediately go to their reset values and any pending result is discarded. After release the block returns to IDLE with no spurious out_valid.
- CHUNK = WIDTH degenerates to a 1-cycle RUN, so latency = 1.

Decomposition:
- Shared package holds:
  - state enum {IDLE, RUN, DONE}
  - the NCHUNK derivation as a function of WIDTH and CHUNK
  - counter width clog2(NCHUNK) (minimum 1)
- One sub-module, adder_chunk:
  - parameter CHUNK.
  - Purely combinational ripple of CHUNK full-adder cells.
  - Outputs the CHUNK-bit sum, the carry out, and the carry into its MSB (needed for overflow).
  - The top level instantiates it once and muxes chunks by cnt.

Test Plan:
- WIDTH=16, CHUNK=4: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, overflow=0; out_valid exactly 4 edges after the input handshake.
- a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, overflow=1. Then a=0x8000, b=0x8000, cin=1 → sum=0x0001, cout=1, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid:
  - sum, cout and overflow stay stable and in_ready stays 0;
  - raise out_ready → out_valid falls next edge and in_ready rises.
- Reset mid-operation: assert rst_n=0 asynchronously during cycle 2 of RUN:
  - outputs go to 0 without waiting for a clock edge;
  - after release, no out_valid appears until a new handshake.
- Parameter sweep (CHUNK=1, 4, 16 with WIDTH=16; CHUNK=1 with WIDTH=1):
  - exhaustive for WIDTH=1, 2000 random vectors otherwise, compared against a + b + cin;
  - latency = WIDTH/CHUNK in every case.
- Handshake rule: drive in_valid=1 continuously with changing operands:
  - exactly one operand set is captured per transaction, and only in IDLE;
  - results match the operands present at the capture edge.

Source files
------------

// File: rtl/chunked_serial_adder_pkg.sv
// Shared types and elaboration helpers for the chunked serial adder.
package chunked_serial_adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Counter needs at least one bit even when a single chunk covers the word.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB
// so the top level can derive signed overflow on the last chunk.
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// WIDTH-bit adder that processes CHUNK bits per clock through a registered
// carry, with valid/ready handshakes on both sides.
module chunked_serial_adder
  import chunked_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $fatal(1, "chunked_serial_adder: illegal WIDTH=%0d CHUNK=%0d", WIDTH, CHUNK);
  end

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_e state, state_nx;
  logic   armed;
  logic   carry;
  logic   cout_r, ovf_r;
  logic [CW-1:0] cnt;
  logic [NCHUNK-1:0][CHUNK-1:0] a_r, b_r, sum_r;

  logic [CHUNK-1:0] ch_sum;
  logic             ch_cout, ch_cmsb;

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_r[cnt]),
    .b     (b_r[cnt]),
    .cin   (carry),
    .sum   (ch_sum),
    .cout  (ch_cout),
    .c_msb (ch_cmsb)
  );

  // armed keeps in_ready low until one edge has passed since reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nx = RUN;
      RUN:     if (cnt == LAST)          state_nx = DONE;
      DONE:    if (out_ready)            state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && armed;
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          a_r   <= a;
          b_r   <= b;
          carry <= cin;
          cnt   <= '0;
        end
        RUN: begin
          sum_r[cnt] <= ch_sum;
          carry      <= ch_cout;
          if (cnt == LAST) begin
            cout_r <= ch_cout;
            ovf_r  <= ch_cmsb ^ ch_cout;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum      = sum_r;
  assign cout     = cout_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder across four WIDTH/CHUNK configurations,
// checked against an arithmetic model of a + b + cin.
`timescale 1ns/1ps
module tb_chunked_serial_adder;

  localparam int NCFG = 4;
  localparam int W_TAB [NCFG] = '{16, 16, 16, 1};
  localparam int C_TAB [NCFG] = '{4, 1, 16, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NCFG-1:0] rst_v, iv_v, or_v, cin_v, ir_all, ovld_all;
  logic [15:0]     a_v [NCFG];
  logic [15:0]     b_v [NCFG];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W = W_TAB[g];
    localparam int C = C_TAB[g];
    localparam int N = W / C;

    typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
    } res_t;

    logic [W-1:0] s;
    logic         co, ov, irdy, ovld;
    res_t         exp_q [$];
    int           hs_q  [$];
    bit           prev_vld;
    logic [W:0]   full;
    res_t         r;

    chunked_serial_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk       (clk),
      .rst_n     (rst_v[g]),
      .in_valid  (iv_v[g]),
      .in_ready  (irdy),
      .a         (a_v[g][W-1:0]),
      .b         (b_v[g][W-1:0]),
      .cin       (cin_v[g]),
      .out_valid (ovld),
      .out_ready (or_v[g]),
      .sum       (s),
      .cout      (co),
      .overflow  (ov)
    );

    assign ir_all[g]   = irdy;
    assign ovld_all[g] = ovld;

    // Scoreboard: capture operands at each handshake, check every valid cycle.
    always @(negedge clk) begin
      if (!rst_v[g]) begin
        exp_q.delete();
        hs_q.delete();
        prev_vld = 1'b0;
      end else begin
        if (ovld) begin
          chk($sformatf("cfg%0d results pending", g), 32'(exp_q.size()), 32'd1);
          if (exp_q.size() != 0) begin
            if (!prev_vld) chk($sformatf("cfg%0d latency", g), 32'(cyc - hs_q[0]), 32'(N));
            chk($sformatf("cfg%0d sum", g),      32'(s),    32'(exp_q[0].sum));
            chk($sformatf("cfg%0d cout", g),     32'(co),   32'(exp_q[0].cout));
            chk($sformatf("cfg%0d overflow", g), 32'(ov),   32'(exp_q[0].ovf));
            chk($sformatf("cfg%0d in_ready in DONE", g), 32'(irdy), 32'd0);
            if (or_v[g]) begin
              void'(exp_q.pop_front());
              void'(hs_q.pop_front());
            end
          end
        end
        if (irdy) chk($sformatf("cfg%0d in_ready while busy", g), 32'(exp_q.size()), 32'd0);
        if (iv_v[g] && irdy) begin
          full  = {1'b0, a_v[g][W-1:0]} + {1'b0, b_v[g][W-1:0]} + (W+1)'(cin_v[g]);
          r.sum  = full[W-1:0];
          r.cout = full[W];
          r.ovf  = (a_v[g][W-1] == b_v[g][W-1]) && (full[W-1] != a_v[g][W-1]);
          exp_q.push_back(r);
          hs_q.push_back(cyc + 1);
        end
        prev_vld = ovld;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic send(input int g, input logic [15:0] a, input logic [15:0] b, input logic ci);
    int n;
    n = 0;
    a_v[g] = a; b_v[g] = b; cin_v[g] = ci; iv_v[g] = 1'b1;
    @(negedge clk);
    while (!ir_all[g] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ir_all[g]) timeout($sformatf("cfg%0d handshake", g));
    @(posedge clk); #1;
    iv_v[g] = 1'b0;
    a_v[g] = 16'($urandom); b_v[g] = 16'($urandom); cin_v[g] = 1'($urandom);
  endtask

  task automatic wait_valid(input int g);
    int n;
    n = 0;
    while (!ovld_all[g] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ovld_all[g]) timeout($sformatf("cfg%0d out_valid", g));
  endtask

  task automatic take(input int g, input int hold);
    repeat (hold) @(posedge clk);
    #1 or_v[g] = 1'b1;
    @(posedge clk); #1;
    or_v[g] = 1'b0;
  endtask

  initial begin
    int hs;
    rst_v = '1; iv_v = '0; or_v = '0; cin_v = '0;
    for (int i = 0; i < NCFG; i++) begin a_v[i] = '0; b_v[i] = '0; end
    #1 rst_v = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready",  32'(g_cfg[0].irdy), 32'd0);
    chk("reset out_valid", 32'(g_cfg[0].ovld), 32'd0);
    chk("reset sum",       32'(g_cfg[0].s),    32'd0);
    chk("reset cout",      32'(g_cfg[0].co),   32'd0);
    chk("reset overflow",  32'(g_cfg[0].ov),   32'd0);
    @(negedge clk);
    rst_v = '1;
    #1 chk("in_ready before first edge", 32'(g_cfg[0].irdy), 32'd0);
    @(posedge clk); #1;
    chk("in_ready after release", 32'(g_cfg[0].irdy), 32'd1);

    // Hand-computed vectors for WIDTH=16, CHUNK=4
    send(0, 16'hFFFF, 16'h0001, 1'b0);
    hs = cyc;
    wait_valid(0);
    chk("ffff+1 latency", 32'(cyc - hs), 32'd4);
    chk("ffff+1 sum",  32'(g_cfg[0].s),  32'h0000);
    chk("ffff+1 cout", 32'(g_cfg[0].co), 32'd1);
    chk("ffff+1 ovf",  32'(g_cfg[0].ov), 32'd0);
    take(0, 0);

    send(0, 16'h7FFF, 16'h0001, 1'b0);
    wait_valid(0);
    chk("7fff+1 sum",  32'(g_cfg[0].s),  32'h8000);
    chk("7fff+1 cout", 32'(g_cfg[0].co), 32'd0);
    chk("7fff+1 ovf",  32'(g_cfg[0].ov), 32'd1);
    take(0, 1);

    send(0, 16'h8000, 16'h8000, 1'b1);
    wait_valid(0);
    chk("8000+8000+1 sum",  32'(g_cfg[0].s),  32'h0001);
    chk("8000+8000+1 cout", 32'(g_cfg[0].co), 32'd1);
    chk("8000+8000+1 ovf",  32'(g_cfg[0].ov), 32'd1);
    take(0, 0);

    // Backpressure: result must hold while out_ready is low
    send(0, 16'h1234, 16'h4321, 1'b1);
    wait_valid(0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp sum",       32'(g_cfg[0].s),    32'h5556);
      chk("bp out_valid", 32'(g_cfg[0].ovld), 32'd1);
      chk("bp in_ready",  32'(g_cfg[0].irdy), 32'd0);
    end
    or_v[0] = 1'b1;
    @(posedge clk); #1;
    or_v[0] = 1'b0;
    chk("bp out_valid falls", 32'(g_cfg[0].ovld), 32'd0);
    chk("bp in_ready rises",  32'(g_cfg[0].irdy), 32'd1);

    // Asynchronous reset during the second RUN cycle
    send(0, 16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #1;
    chk("partial chunk0", 32'(g_cfg[0].s[3:0]), 32'h5);
    #2 rst_v[0] = 1'b0;
    #1;
    chk("async rst sum",       32'(g_cfg[0].s),    32'd0);
    chk("async rst out_valid", 32'(g_cfg[0].ovld), 32'd0);
    chk("async rst in_ready",  32'(g_cfg[0].irdy), 32'd0);
    chk("async rst cout",      32'(g_cfg[0].co),   32'd0);
    chk("async rst overflow",  32'(g_cfg[0].ov),   32'd0);
    @(posedge clk); #1;
    rst_v[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("no out_valid after reset", 32'(g_cfg[0].ovld), 32'd0);
    end
    chk("in_ready after mid-op reset", 32'(g_cfg[0].irdy), 32'd1);

    // in_valid held high with operands changing every cycle
    or_v[0] = 1'b1;
    iv_v[0] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a_v[0] = 16'($urandom); b_v[0] = 16'($urandom); cin_v[0] = 1'($urandom);
      @(posedge clk); #1;
    end
    iv_v[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1 or_v[0] = 1'b0;

    // Parameter sweep: exhaustive for WIDTH=1, random otherwise
    for (int g = 0; g < NCFG; g++) begin
      if (W_TAB[g] == 1) begin
        for (int v = 0; v < 8; v++) begin
          send(g, 16'(v & 1), 16'((v >> 1) & 1), 1'((v >> 2) & 1));
          wait_valid(g);
          take(g, $urandom_range(0, 1));
        end
      end else begin
        for (int v = 0; v < 2000; v++) begin
          send(g, 16'($urandom), 16'($urandom), 1'($urandom));
          wait_valid(g);
          take(g, $urandom_range(0, 1));
        end
      end
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
